// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - PLL-lock filtered, ordered multi-domain reset release
//
// Purpose:
//   Synchronises pll_lock, waits until it has stayed high for LOCK_CYCLES,
//   then releases rst_n_out[0], rst_n_out[1], ... rst_n_out[N_DOMAINS-1]
//   one after another, STAGE_DELAY cycles apart. Losing lock or a soft reset
//   request re-asserts the resets and restarts the whole sequence.
//   Optional macro RESET_SEQUENCER_ORDERED_ASSERT_EN: on abort, released
//   domains are re-asserted one per cycle in reverse order instead of together.
//
// Ports:
//   clk              sequencer clock (PLL output)
//   rst_n            synchronous active-low reset
//   pll_lock         raw PLL lock, asynchronous to clk
//   soft_rst_req     level request to re-run the sequence
//   rst_n_out        per-domain active-low resets, bit k = domain k
//   ready            all domains released
//   lock_loss_count  saturating count of lock losses after release began

module reset_sequencer #(
    parameter int N_DOMAINS   = 3,
    parameter int LOCK_CYCLES = 256,
    parameter int STAGE_DELAY = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pll_lock,
    input  logic                 soft_rst_req,
    output logic [N_DOMAINS-1:0] rst_n_out,
    output logic                 ready,
    output logic [7:0]           lock_loss_count
);

    localparam int LW = $clog2(LOCK_CYCLES + 1);
    localparam int SW = $clog2(STAGE_DELAY + 1);

    typedef enum logic [2:0] {
        ST_HOLD,
        ST_FILTER,
        ST_RELEASE,
        ST_RUN
`ifdef RESET_SEQUENCER_ORDERED_ASSERT_EN
        , ST_DRAIN
`endif
    } state_t;

    state_t               state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [LW-1:0]        cnt_q, cnt_d;
    logic [SW-1:0]        timer_q, timer_d;
    logic [N_DOMAINS-1:0] rst_n_out_q, rst_n_out_d;
    logic                 ready_q, ready_d;
    logic [7:0]           lock_loss_count_q, lock_loss_count_d;

    logic                 lock_s;
    logic                 abort;
    logic [N_DOMAINS-1:0] released_next;

    assign lock_s = sync_q[SYNC_STAGES-1];
    assign abort  = !lock_s || soft_rst_req;

    // Released bits are always contiguous from domain 0, so releasing the
    // next domain is a shift-in of a one; the stage index is implicit.
    assign released_next = N_DOMAINS'({rst_n_out_q, 1'b1});

`ifdef RESET_SEQUENCER_ORDERED_ASSERT_EN
    // Shifting right re-asserts the highest released domain first.
    logic [N_DOMAINS-1:0] drained_next;
    assign drained_next = rst_n_out_q >> 1;
`endif

    always_comb begin
        state_d           = state_q;
        sync_d            = {sync_q[SYNC_STAGES-2:0], pll_lock};
        cnt_d             = cnt_q;
        timer_d           = timer_q;
        rst_n_out_d       = rst_n_out_q;
        ready_d           = ready_q;
        lock_loss_count_d = lock_loss_count_q;

        case (state_q)
            ST_HOLD: begin
                rst_n_out_d = '0;
                ready_d     = 1'b0;
                cnt_d       = '0;
                timer_d     = '0;
                if (!abort) begin
                    state_d = ST_FILTER;
                end
            end

            ST_FILTER: begin
                if (abort) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end else if (cnt_q == LW'(LOCK_CYCLES - 1)) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                    timer_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_RELEASE, ST_RUN: begin
                if (abort) begin
                    // Only a lock drop counts; a coincident soft request
                    // still counts exactly once.
                    if (!lock_s && lock_loss_count_q != 8'hFF) begin
                        lock_loss_count_d = lock_loss_count_q + 8'd1;
                    end
                    ready_d = 1'b0;
                    timer_d = '0;
`ifdef RESET_SEQUENCER_ORDERED_ASSERT_EN
                    rst_n_out_d = drained_next;
                    state_d     = (drained_next == '0) ? ST_HOLD : ST_DRAIN;
`else
                    rst_n_out_d = '0;
                    state_d     = ST_HOLD;
`endif
                end else if (state_q == ST_RELEASE) begin
                    if (timer_q == SW'(STAGE_DELAY - 1)) begin
                        timer_d     = '0;
                        rst_n_out_d = released_next;
                        if (released_next[N_DOMAINS-1]) begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end else begin
                    ready_d = 1'b1;
                end
            end

`ifdef RESET_SEQUENCER_ORDERED_ASSERT_EN
            ST_DRAIN: begin
                // Abort inputs are deliberately not looked at here.
                ready_d     = 1'b0;
                rst_n_out_d = drained_next;
                if (drained_next == '0) begin
                    state_d = ST_HOLD;
                end
            end
`endif

            default: begin
                state_d     = ST_HOLD;
                rst_n_out_d = '0;
                ready_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q           <= ST_HOLD;
            sync_q            <= '0;
            cnt_q             <= '0;
            timer_q           <= '0;
            rst_n_out_q       <= '0;
            ready_q           <= 1'b0;
            lock_loss_count_q <= 8'd0;
        end else begin
            state_q           <= state_d;
            sync_q            <= sync_d;
            cnt_q             <= cnt_d;
            timer_q           <= timer_d;
            rst_n_out_q       <= rst_n_out_d;
            ready_q           <= ready_d;
            lock_loss_count_q <= lock_loss_count_d;
        end
    end

    assign rst_n_out       = rst_n_out_q;
    assign ready           = ready_q;
    assign lock_loss_count = lock_loss_count_q;

endmodule
